multu_alu_responder: RTL and testbench
======================================

Name: multu_alu_responder

Overview:
- Hardware responder for the ALU command interface the team's ALU benches drive: function code on `signal`, operands on `dataA`/`dataB`, registered 32-bit result on `dataOut`.
- Executes single-cycle logic, arithmetic and shift ops.
- Runs MULTU as a 32-iteration sequential shift-add into HI/LO registers; reads them back through the HI/LO move codes.
- Sits behind the datapath controller as the ALU + multiplier execution unit.

Parameters:
- WIDTH, 32, operand and result width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- signal  input  6  function code: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, SLL=0, MULTU=25, HI=61, LO=60.
- dataA  input  WIDTH  operand A; shift source for SRL/SLL; multiplicand for MULTU.
- dataB  input  WIDTH  operand B; shift amount (bits [4:0]) for SRL/SLL; multiplier for MULTU.
- dataOut  output  WIDTH  registered result.
- busy  output  1  high while a MULTU is in progress (state != IDLE).

Behaviour:
- Reset (synchronous, active-high) forces:
  - dataOut=0, busy=0, HI=0, LO=0, state=IDLE, counter=0, armed=0.
  - Applies even mid-MULTU; the partial product is discarded.
- Result latency: dataOut updates on the rising edge after signal/dataA/dataB are sampled (1-cycle latency).
- Op semantics:
  - AND and OR are bitwise.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is a signed compare: 1 when $signed(A) < $signed(B), else 0.
  - SRL = A >> B[4:0], logical (zero fill).
  - SLL = A << B[4:0].
  - HI returns the HI register; LO returns the LO register.
  - MULTU returns dataOut=0.
  - Any other code returns 0.
- MULTU start:
  - armed = registered (signal != MULTU).
  - A start occurs when signal==MULTU, armed==1 and state==IDLE.
  - Holding MULTU for many cycles therefore starts exactly one multiply.
  - A MULTU code presented while busy is ignored; it does not queue.
- MULTU FSM:
  - IDLE -> RUN on start: latch mcand = {0, A} (2*WIDTH bits), mplier = B, acc = 0, counter = 0.
  - RUN, each cycle:
    - if mplier[0]=1, acc += mcand (2*WIDTH-bit add, no carry out).
    - mcand <<= 1; mplier >>= 1; counter += 1.
    - After the iteration with counter==WIDTH-1, go to DONE.
  - DONE: HI <= acc[2W-1:W], LO <= acc[W-1:0]; go to IDLE.
- MULTU timing: start sampled at edge N; RUN covers edges N+1..N+32; DONE at edge N+33. busy=1 from after edge N until after edge N+33.
- HI/LO during RUN and DONE: reads return the previous product; new values are visible from the cycle after DONE.
- Simultaneous events: reset has priority over everything. The HI/LO write in DONE and a same-cycle HI/LO read both occur; dataOut shows the pre-write value.

Optional Feature:
- Macro: MULTU_EARLY_TERM_EN.
- Defined:
  - In RUN, if the post-shift mplier equals 0, go to DONE next cycle regardless of counter.
  - When B=0 at start, go directly to DONE after one RUN cycle.
  - HI/LO results are identical to the full-length run.
- Undefined: always exactly WIDTH RUN cycles.

Test Plan:
- Reset held 2 cycles, then signal=61, then 60 -> dataOut=0 both cycles; busy=0.
- ADD A=5,B=7 -> 12. SUB A=3,B=5 -> 0xFFFFFFFE. SLT A=0xFFFFFFFF,B=1 -> 1. AND 0xF0F0,0xFF00 -> 0xF000.
- SLL A=1,B=31 -> 0x80000000. SRL A=0x80000000,B=36 (shamt 4) -> 0x08000000.
- MULTU A=B=0xFFFFFFFF held 33 cycles -> busy=1 for 33 cycles. Then signal=61 -> 0xFFFFFFFE; signal=60 -> 0x00000001. An extra cycle of held MULTU must not restart the multiply.
- MULTU A=7,B=9; assert reset at RUN cycle 10 -> busy=0 next cycle; HI read 0, LO read 0; a new MULTU 7*9 then gives LO=63.
- Macro defined: MULTU A=1000,B=3 -> busy high for exactly 3 cycles (2 RUN + DONE); LO=3000, HI=0. Macro undefined: busy high for 33 cycles, same result.

Source files
------------

// File: rtl/multu_alu_responder.sv
// ALU responder: single-cycle logic/arith/shift ops plus a sequential shift-add MULTU into HI/LO.
// Optional macro MULTU_EARLY_TERM_EN ends the multiply as soon as the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for an armed MULTU start
// RUN   | one shift-add iteration per cycle
// DONE  | commit accumulator to HI/LO, return to IDLE
module multu_alu_responder #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy
);

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_LO    = 6'd60;
    localparam logic [5:0] F_HI    = 6'd61;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_armed;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic [WIDTH-1:0]       r_dout;

    logic                   w_start;
    logic [WIDTH-1:0]       w_mplier_nxt;
    logic [WIDTH-1:0]       w_alu;
    logic                   w_slt;

    assign w_start      = (signal == F_MULTU) && r_armed && (r_state == S_IDLE);
    assign w_mplier_nxt = r_mplier >> 1;
    assign w_slt        = $signed(dataA) < $signed(dataB);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
`ifdef MULTU_EARLY_TERM_EN
                if ((w_mplier_nxt == '0) || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = S_DONE;
                end
`else
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Multiplier datapath and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            // A held MULTU code only arms once it has been released for a cycle
            r_armed <= (signal != F_MULTU);
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, dataA};
                        r_mplier <= dataB;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_hi <= r_acc[2*WIDTH-1:WIDTH];
                    r_lo <= r_acc[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_alu = '0;
        case (signal)
            F_AND:   w_alu = dataA & dataB;
            F_OR:    w_alu = dataA | dataB;
            F_ADD:   w_alu = dataA + dataB;
            F_SUB:   w_alu = dataA - dataB;
            F_SLT:   w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            F_SRL:   w_alu = dataA >> dataB[4:0];
            F_SLL:   w_alu = dataA << dataB[4:0];
            F_HI:    w_alu = r_hi;
            F_LO:    w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_alu;
        end
    end

    assign dataOut = r_dout;

endmodule

// File: tb/tb_multu_alu_responder.sv
// Directed bench for multu_alu_responder: ALU ops, MULTU timing, hold/no-restart, reset abort.
// Expected busy length depends on MULTU_EARLY_TERM_EN.
module tb_multu_alu_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataOut;
    logic        busy;

    int total = 0;
    int bad   = 0;

    multu_alu_responder #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .signal  (signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy drops, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            cyc();
            n++;
        end
        check("mult_timeout", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [5:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   n;
    int   exp_short;

    initial begin
        vecs[0]  = '{"add",      6'd32, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{"sub",      6'd34, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2]  = '{"slt_t",    6'd42, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[3]  = '{"and",      6'd36, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        vecs[4]  = '{"sll",      6'd0,  32'd1,          32'd31,         32'h8000_0000};
        vecs[5]  = '{"srl",      6'd2,  32'h8000_0000,  32'd36,         32'h0800_0000};
        vecs[6]  = '{"or",       6'd37, 32'h0000_F0F0,  32'h0000_0F00,  32'h0000_FFF0};
        vecs[7]  = '{"slt_f",    6'd42, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[8]  = '{"add_wrap", 6'd32, 32'hFFFF_FFFF,  32'd2,          32'd1};
        vecs[9]  = '{"bad_code", 6'd63, 32'h1234_5678,  32'h1111_1111,  32'd0};
        vecs[10] = '{"srl_zero", 6'd2,  32'hF000_0000,  32'd28,         32'h0000_000F};
        vecs[11] = '{"sll_big",  6'd0,  32'h0000_0003,  32'd33,         32'h0000_0006};

`ifdef MULTU_EARLY_TERM_EN
        exp_short = 3;
`else
        exp_short = 33;
`endif

        reset  = 1'b1;
        signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        cyc();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dout", dataOut, 32'd0);
        cyc();
        reset  = 1'b0;
        signal = 6'd61;
        cyc();
        check("hi_after_rst", dataOut, 32'd0);
        signal = 6'd60;
        cyc();
        check("lo_after_rst", dataOut, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) begin
            signal = vecs[i].sig;
            dataA  = vecs[i].a;
            dataB  = vecs[i].b;
            cyc();
            check(vecs[i].tag, dataOut, vecs[i].exp);
        end

        // Full-width multiply with MULTU held throughout
        signal = 6'd25;
        dataA  = 32'hFFFF_FFFF;
        dataB  = 32'hFFFF_FFFF;
        cyc();
        check("mult_start_busy", {31'd0, busy}, 32'd1);
        check("mult_dout0", dataOut, 32'd0);
        wait_idle(n);
        check("mult_busy_len", n, 32'd33);
        cyc();
        check("no_restart", {31'd0, busy}, 32'd0);
        signal = 6'd61;
        cyc();
        check("ff_hi", dataOut, 32'hFFFF_FFFE);
        signal = 6'd60;
        cyc();
        check("ff_lo", dataOut, 32'h0000_0001);

        // Start 7*9 and abort with reset during RUN
        signal = 6'd25;
        dataA  = 32'd7;
        dataB  = 32'd9;
        cyc();
        check("abort_start", {31'd0, busy}, 32'd1);
        signal = 6'd61;
        cyc();
        check("hi_during_run", dataOut, 32'hFFFF_FFFE);
        repeat (9) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        signal = 6'd61;
        cyc();
        check("abort_hi", dataOut, 32'd0);
        signal = 6'd60;
        cyc();
        check("abort_lo", dataOut, 32'd0);

        signal = 6'd25;
        dataA  = 32'd7;
        dataB  = 32'd9;
        cyc();
        check("m79_busy", {31'd0, busy}, 32'd1);
        signal = 6'd60;
        wait_idle(n);
        cyc();
        check("m79_lo", dataOut, 32'd63);
        signal = 6'd61;
        cyc();
        check("m79_hi", dataOut, 32'd0);

        // Short multiplier: length depends on early termination
        signal = 6'd25;
        dataA  = 32'd1000;
        dataB  = 32'd3;
        cyc();
        wait_idle(n);
        check("m1000x3_len", n, exp_short);
        signal = 6'd60;
        cyc();
        check("m1000x3_lo", dataOut, 32'd3000);
        signal = 6'd61;
        cyc();
        check("m1000x3_hi", dataOut, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
